btn_event_arbiter: RTL and testbench

//  Sits between the debounced push-button bank and the menu/game logic.
//  - Turns debounced rising-edge pulses into a queue of single button events,
//    so simultaneous presses are never lost or merged.
//  - Generates auto-repeat events while a single button is held.
//  - Consumers pop events with a valid/ready handshake.

---
 rtl/btn_event_arbiter.sv | 173 +++++++++++++++++
 tb/tb_btn_event_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/btn_event_arbiter.sv
// Push-button event arbiter: per-button pending flags, a round-robin grant into
// a small event FIFO, and an auto-repeat generator for a held button.

module btn_pend_lane (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic tick,
  input  logic grant,
  output logic pend,
  output logic pend_rep,
  output logic ovf_hit
);
  // A press already waiting and not leaving this cycle is merged away.
  assign ovf_hit = press & pend & ~grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_rep <= 1'b0;
    end else if (press) begin
      pend     <= 1'b1;
      pend_rep <= 1'b0;
    end else if (tick && !(pend && !grant)) begin
      pend     <= 1'b1;
      pend_rep <= 1'b1;
    end else if (grant) begin
      pend     <= 1'b0;
    end
  end
endmodule

module btn_event_arbiter #(
  parameter int NUM_BTNS     = 5,
  parameter int IDX_W        = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int CNT_W        = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_level,
  input  logic [NUM_BTNS-1:0] btn_posedge,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_btn,
  output logic                evt_repeat,
  output logic                ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DELAY, RATE} rstate_t;

  logic [NUM_BTNS-1:0] pend, pend_rep, grant, tick, ovf_hit;
  logic [IDX_W-1:0]    rr, gidx;
  logic                gnt_vld, found;
  logic [IDX_W:0]      mem [FIFO_DEPTH];
  logic [AW:0]         wp, rp;
  logic                full, empty, pop, can_push;
  rstate_t             state;
  logic [IDX_W-1:0]    last, lo_idx;
  logic [CNT_W-1:0]    cnt;
  logic                any_pe, held, rep_tick;

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_lane
    btn_pend_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .press    (btn_posedge[b]),
      .tick     (tick[b]),
      .grant    (grant[b]),
      .pend     (pend[b]),
      .pend_rep (pend_rep[b]),
      .ovf_hit  (ovf_hit[b])
    );
  end

  // FIFO status; head is read straight out of storage.
  assign empty     = (wp == rp);
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign evt_valid = ~empty;
  assign pop       = evt_valid & evt_ready;
  assign can_push  = ~full | pop;
  assign {evt_btn, evt_repeat} = mem[rp[AW-1:0]];

  // Round-robin search starting at rr.
  always_comb begin
    grant   = '0;
    gidx    = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      int idx;
      idx = int'(rr) + i;
      if (idx >= NUM_BTNS) idx = idx - NUM_BTNS;
      if (!found && pend[idx]) begin
        found = 1'b1;
        gidx  = IDX_W'(idx);
      end
    end
    gnt_vld = found & can_push;
    if (gnt_vld) grant[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (gnt_vld) begin
        mem[wp[AW-1:0]] <= {gidx, pend_rep[gidx]};
        wp <= wp + 1'b1;
        rr <= (int'(gidx) == NUM_BTNS - 1) ? '0 : gidx + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           ovf <= 1'b0;
    else if (|ovf_hit) ovf <= 1'b1;
  end

  // Auto-repeat: lowest-index new press owns the timer.
  always_comb begin
    lo_idx = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--)
      if (btn_posedge[i]) lo_idx = IDX_W'(i);
  end

  assign any_pe   = |btn_posedge;
  assign held     = btn_level[last];
  // A new press restarts timing, so it suppresses a tick due the same cycle.
  assign rep_tick = !any_pe && held &&
                    ((state == DELAY && cnt == CNT_W'(REPEAT_DELAY - 1)) ||
                     (state == RATE  && cnt == CNT_W'(REPEAT_RATE - 1)));

  always_comb begin
    tick = '0;
    for (int i = 0; i < NUM_BTNS; i++)
      tick[i] = rep_tick && (last == IDX_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= '0;
      cnt   <= '0;
    end else if (any_pe) begin
      state <= DELAY;
      last  <= lo_idx;
      cnt   <= '0;
    end else begin
      case (state)
        DELAY: begin
          if (!held) state <= IDLE;
          else if (cnt == CNT_W'(REPEAT_DELAY - 1)) begin
            cnt   <= '0;
            state <= RATE;
          end else cnt <= cnt + CNT_W'(1);
        end
        RATE: begin
          if (!held) state <= IDLE;
          else if (cnt == CNT_W'(REPEAT_RATE - 1)) cnt <= '0;
          else cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: per-cycle vector table plus a
// hand-written auto-repeat sequence.

module tb_btn_event_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_level = '0;
  logic [4:0] btn_posedge = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_btn;
  logic       evt_repeat;
  logic       ovf;

  int checks = 0;
  int failures = 0;

  btn_event_arbiter #(
    .NUM_BTNS(5), .IDX_W(3), .FIFO_DEPTH(2),
    .REPEAT_DELAY(8), .REPEAT_RATE(3), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_level(btn_level), .btn_posedge(btn_posedge),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_btn(evt_btn),
    .evt_repeat(evt_repeat), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // chk: bit0 checks valid/ovf, bit1 also checks head btn/repeat.
  typedef struct packed {
    logic       rst;
    logic [4:0] pe;
    logic [4:0] lvl;
    logic       rdy;
    logic [1:0] chk;
    logic       v;
    logic [2:0] b;
    logic       r;
    logic       o;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic r_, input logic [4:0] pe, input logic rdy,
                      input logic [1:0] chk, input logic v, input logic [2:0] b,
                      input logic o);
    vec_t t;
    t.rst = r_; t.pe = pe; t.lvl = '0; t.rdy = rdy; t.chk = chk;
    t.v = v; t.b = b; t.r = 1'b0; t.o = o;
    tbl.push_back(t);
  endtask

  task automatic cmp(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  initial begin
    // test 1: single press, 2-cycle latency
    addv(1, 5'b00000, 1, 0, 0, 0, 0);
    addv(0, 5'b00000, 1, 1, 0, 0, 0);
    addv(0, 5'b00100, 1, 1, 0, 0, 0);
    addv(0, 5'b00000, 1, 1, 0, 0, 0);
    addv(0, 5'b00000, 1, 3, 1, 2, 0);
    addv(0, 5'b00000, 1, 1, 0, 0, 0);
    addv(0, 5'b00000, 1, 1, 0, 0, 0);
    // test 2: simultaneous presses 0,1,4
    addv(1, 5'b00000, 1, 0, 0, 0, 0);
    addv(0, 5'b00000, 1, 1, 0, 0, 0);
    addv(0, 5'b10011, 1, 1, 0, 0, 0);
    addv(0, 5'b00000, 1, 1, 0, 0, 0);
    addv(0, 5'b00000, 1, 3, 1, 0, 0);
    addv(0, 5'b00000, 1, 3, 1, 1, 0);
    addv(0, 5'b00000, 1, 3, 1, 4, 0);
    addv(0, 5'b00000, 1, 1, 0, 0, 0);
    // test 3: backpressure holds pending presses
    addv(1, 5'b00000, 0, 0, 0, 0, 0);
    addv(0, 5'b00000, 0, 1, 0, 0, 0);
    addv(0, 5'b00001, 0, 1, 0, 0, 0);
    addv(0, 5'b00010, 0, 1, 0, 0, 0);
    addv(0, 5'b00100, 0, 3, 1, 0, 0);
    addv(0, 5'b01000, 0, 3, 1, 0, 0);
    addv(0, 5'b00000, 0, 3, 1, 0, 0);
    addv(0, 5'b00000, 1, 3, 1, 0, 0);
    addv(0, 5'b00000, 1, 3, 1, 1, 0);
    addv(0, 5'b00000, 1, 3, 1, 2, 0);
    addv(0, 5'b00000, 1, 3, 1, 3, 0);
    addv(0, 5'b00000, 1, 1, 0, 0, 0);
    // test 5: repeated press on a blocked button merges and flags ovf
    addv(1, 5'b00000, 0, 0, 0, 0, 0);
    addv(0, 5'b00000, 0, 1, 0, 0, 0);
    addv(0, 5'b00001, 0, 1, 0, 0, 0);
    addv(0, 5'b00100, 0, 1, 0, 0, 0);
    addv(0, 5'b00000, 0, 3, 1, 0, 0);
    addv(0, 5'b00010, 0, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++) addv(0, 5'b00000, 0, 3, 1, 0, 0);
    addv(0, 5'b00010, 0, 3, 1, 0, 0);
    addv(0, 5'b00000, 0, 3, 1, 0, 1);
    addv(0, 5'b00000, 1, 3, 1, 0, 1);
    addv(0, 5'b00000, 1, 3, 1, 2, 1);
    addv(0, 5'b00000, 1, 3, 1, 1, 1);
    addv(0, 5'b00000, 1, 1, 0, 0, 1);
    addv(0, 5'b00000, 1, 1, 0, 0, 1);
    // test 6: reset with FIFO and pending non-empty
    addv(0, 5'b00001, 0, 1, 0, 0, 1);
    addv(0, 5'b01000, 0, 1, 0, 0, 1);
    addv(0, 5'b00100, 0, 3, 1, 0, 1);
    addv(1, 5'b00010, 0, 3, 1, 0, 1);
    for (int i = 0; i < 4; i++) addv(0, 5'b00000, 1, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].chk[0]) begin
        cmp("valid", i, 32'(evt_valid), 32'(tbl[i].v));
        cmp("ovf", i, 32'(ovf), 32'(tbl[i].o));
      end
      if (tbl[i].chk[1]) begin
        cmp("btn", i, 32'(evt_btn), 32'(tbl[i].b));
        cmp("repeat", i, 32'(evt_repeat), 32'(tbl[i].r));
      end
      rst         = tbl[i].rst;
      btn_posedge = tbl[i].pe;
      btn_level   = tbl[i].lvl;
      evt_ready   = tbl[i].rdy;
    end

    // test 4: hold btn 3 from c=20, release at c=35
    @(negedge clk);
    rst = 1'b1; btn_posedge = '0; btn_level = '0; evt_ready = 1'b1;
    for (int c = 0; c < 46; c++) begin
      logic ev;
      @(negedge clk);
      ev = (c == 22) || (c == 30) || (c == 33) || (c == 36);
      if (c > 0) begin
        cmp("rpt_valid", 1000 + c, 32'(evt_valid), 32'(ev));
        cmp("rpt_ovf", 1000 + c, 32'(ovf), 32'd0);
        if (ev) begin
          cmp("rpt_btn", 1000 + c, 32'(evt_btn), 32'd3);
          cmp("rpt_flag", 1000 + c, 32'(evt_repeat), 32'(c != 22));
        end
      end
      rst         = 1'b0;
      btn_posedge = (c == 20) ? 5'b01000 : 5'b00000;
      btn_level   = (c >= 20 && c <= 34) ? 5'b01000 : 5'b00000;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
